// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Width of an iteration counter that must hold values 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_ripple_sub.sv
// Ripple-borrow subtractor a_i - b_i built from full_adder cells (b inverted, carry-in 1).
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module ripple_sub #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign borrow_o = ~carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional feature: define DIV_ZERO_CHECK_EN to short-circuit divide-by-zero in one cycle.
module restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    // Partial remainder top bit is always zero after a step, so only WIDTH bits are kept.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_t;
    logic             borrow;
    logic             unused_trial_msb;
    logic [WIDTH-1:0] a_step;
    logic [WIDTH-1:0] q_step;

    assign trial_a = {a_q, q_q[WIDTH-1]};
    assign trial_b = {1'b0, m_q};

    ripple_sub #(
        .N (WIDTH + 1)
    ) u_sub (
        .a_i      (trial_a),
        .b_i      (trial_b),
        .diff_o   (trial_t),
        .borrow_o (borrow)
    );

    // Borrow (not T's MSB) decides the step: with a zero divisor the shifted value may exceed WIDTH bits.
    assign unused_trial_msb = trial_t[WIDTH];
    assign a_step = borrow ? trial_a[WIDTH-1:0] : trial_t[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], ~borrow};

`ifdef DIV_ZERO_CHECK_EN
    logic dbz_q, dbz_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (Run) begin
                    a_d     = '0;
                    q_d     = Dividend;
                    m_d     = Divisor;
                    cnt_d   = '0;
                    state_d = ITER;
`ifdef DIV_ZERO_CHECK_EN
                    if (Divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            ITER: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quot_d  = q_step;
                    rem_d   = a_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
`ifdef DIV_ZERO_CHECK_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign Busy      = (state_q == ITER);
    assign Done      = (state_q == DONE);
`ifdef DIV_ZERO_CHECK_EN
    assign DivByZero = dbz_q;
`else
    assign DivByZero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider (WIDTH=8); honours DIV_ZERO_CHECK_EN.
module tb_restoring_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    restoring_divider #(
        .WIDTH (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit scramble);
        exp_t e;
        int   edges;
        @(negedge Clk);
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        e.q = (b == 8'd0) ? 8'hFF : a / b;
        e.r = (b == 8'd0) ? a : a % b;
`ifdef DIV_ZERO_CHECK_EN
        e.dz  = (b == 8'd0);
        e.lat = (b == 8'd0) ? 1 : 9;
`else
        e.dz  = 1'b0;
        e.lat = 9;
`endif
        sb.push_back(e);
        edges = 0;
        do begin
            @(negedge Clk);
            edges++;
            if (edges == 1 && e.lat > 1) begin
                total++;
                if (Busy !== 1'b1) $display("FAIL busy_after_start %0d/%0d got %b want 1", a, b, Busy);
                else passed++;
            end
            if (scramble && edges == 3) begin
                Dividend = 8'($urandom);
                Divisor  = 8'($urandom);
                Run      = 1'b0;
            end
            if (scramble && edges == 5) Run = 1'b1;
        end while (!Done && edges < 30);
        e = sb.pop_front();
        total++;
        if (edges !== e.lat) $display("FAIL latency %0d/%0d got %0d want %0d", a, b, edges, e.lat);
        else passed++;
        total++;
        if ({Quotient, Remainder, DivByZero} !== {e.q, e.r, e.dz})
            $display("FAIL result %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     a, b, Quotient, Remainder, DivByZero, e.q, e.r, e.dz);
        else passed++;
        repeat (3) @(negedge Clk);
        total++;
        if ({Done, Busy, Quotient, Remainder} !== {1'b1, 1'b0, e.q, e.r})
            $display("FAIL hold_in_done %0d/%0d got done=%b busy=%b q=%0d r=%0d want done=1 busy=0 q=%0d r=%0d",
                     a, b, Done, Busy, Quotient, Remainder, e.q, e.r);
        else passed++;
        Run = 1'b0;
        @(negedge Clk);
        total++;
        if ({Done, DivByZero, Quotient, Remainder} !== {1'b0, 1'b0, e.q, e.r})
            $display("FAIL release_run %0d/%0d got done=%b dz=%b q=%0d r=%0d want done=0 dz=0 q=%0d r=%0d",
                     a, b, Done, DivByZero, Quotient, Remainder, e.q, e.r);
        else passed++;
        @(negedge Clk);
        total++;
        if ({Busy, Done} !== 2'b00) $display("FAIL idle_no_restart %0d/%0d got busy=%b done=%b want 00", a, b, Busy, Done);
        else passed++;
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        Run      = 1'b0;
        Dividend = 8'd0;
        Divisor  = 8'd0;
        repeat (2) @(negedge Clk);
        total++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0)
            $display("FAIL reset_state got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        else passed++;
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        run_op(8'd200, 8'd7,   1'b0);
        run_op(8'd255, 8'd1,   1'b0);
        run_op(8'd5,   8'd9,   1'b0);
        run_op(8'd128, 8'd128, 1'b0);
        run_op(8'd0,   8'd3,   1'b0);
        run_op(8'd255, 8'd255, 1'b0);
    endtask

    task automatic test_div_zero();
        run_op(8'd37,  8'd0, 1'b0);
        run_op(8'd255, 8'd0, 1'b0);
    endtask

    task automatic test_reset_mid_iter();
        @(negedge Clk);
        Dividend = 8'd200;
        Divisor  = 8'd7;
        Run      = 1'b1;
        repeat (4) @(negedge Clk);
        total++;
        if (Busy !== 1'b1) $display("FAIL busy_mid_iter got %b want 1", Busy);
        else passed++;
        Reset = 1'b1;
        @(negedge Clk);
        total++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== 19'd0)
            $display("FAIL reset_mid_iter got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        else passed++;
        Reset = 1'b0;
        Run   = 1'b0;
        @(negedge Clk);
        run_op(8'd100, 8'd10, 1'b0);
    endtask

    task automatic test_operand_change();
        run_op(8'd200, 8'd7,  1'b1);
        run_op(8'd99,  8'd13, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_reset_mid_iter();
        test_operand_change();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
